// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode masks, source-field encodings, fetch states and the
// needs_data helper so the fetch unit and the decoder agree on operand fetches.
// Optional macro FETCH_TIMEOUT_EN adds the FAULT fetch state.
package cpu_pkg;
  localparam logic [15:0] CLASS_MASK  = 16'hC000;
  localparam logic [15:0] OPCODE_MASK = 16'hF800;
  localparam logic [15:0] CLASS_ONE_ARG = 16'h8000;
  localparam logic [2:0] SRC_IMM_LO  = 3'b000;
  localparam logic [2:0] SRC_IMM_HI  = 3'b001;
  localparam logic [2:0] SRC_DATA_LO = 3'b010;
  localparam logic [2:0] SRC_DATA_HI = 3'b011;
  localparam logic [2:0] SRC_RAM     = 3'b100;
  typedef enum logic [2:0] {
    FETCH_HI,
    FETCH_LO,
    FETCH_DATA,
    ISSUE
`ifdef FETCH_TIMEOUT_EN
    , FAULT
`endif
  } fetch_state_e;
  // Source field is inst[10:8]; DATA_LO and DATA_HI share the upper two bits.
  function automatic logic needs_data(input logic [15:0] inst);
    return ((inst & CLASS_MASK) == CLASS_ONE_ARG) && (inst[10:9] == SRC_DATA_LO[2:1]);
  endfunction
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: fetches 16-bit instructions (high byte first) plus an optional
// data byte over an 8-bit memory bus and issues them with a hold-until-accepted
// handshake; owns the PC including sequential advance and taken branches.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mem_req/mem_addr      byte read request and address (out)
//   mem_ack/mem_rdata     transfer completion and read byte (in)
//   en/inst/data/pc       issued instruction, data byte and its address (out)
//   exec_ready            execute stage accepts the issued instruction (in)
//   branch_take/offset    taken branch with signed byte offset, sampled on accept
//   fault                 bus timeout flag
// Optional macro FETCH_TIMEOUT_EN: bus timeout counter and FAULT state;
// without it fault is tied 0 and the unit waits indefinitely for mem_ack.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        en,
  output logic [15:0] inst,
  output logic [7:0]  data,
  input  logic        exec_ready,
  input  logic        branch_take,
  input  logic [15:0] branch_offset,
  output logic [15:0] pc,
  output logic        fault
);
  fetch_state_e state, state_nx;
  logic [15:0] fp;
  logic ack, accept, word_needs_data;
  // Gating with rst_n keeps the bus idle while reset is held.
  assign mem_req = rst_n && (state == FETCH_HI || state == FETCH_LO || state == FETCH_DATA);
  assign mem_addr = fp;
  assign en = state == ISSUE;
  assign ack = mem_req && mem_ack;
  assign accept = en && exec_ready;
  assign word_needs_data = needs_data({inst[15:8], mem_rdata});
`ifdef FETCH_TIMEOUT_EN
  logic [15:0] cnt;
  logic expire;
  assign expire = mem_req && !mem_ack && (cnt == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      fault <= 1'b0;
    end else begin
      cnt <= (mem_req && !mem_ack) ? cnt + 16'd1 : '0;
      if (expire) fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH_HI;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      FETCH_HI:   state_nx = ack ? FETCH_LO : FETCH_HI;
      FETCH_LO:   state_nx = !ack ? FETCH_LO : word_needs_data ? FETCH_DATA : ISSUE;
      FETCH_DATA: state_nx = ack ? ISSUE : FETCH_DATA;
      ISSUE:      state_nx = exec_ready ? FETCH_HI : ISSUE;
      default:    state_nx = state;
    endcase
`ifdef FETCH_TIMEOUT_EN
    if (expire) state_nx = FAULT;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fp <= RESET_PC;
      pc <= RESET_PC;
      inst <= '0;
      data <= '0;
    end else begin
      if (state == FETCH_HI) pc <= fp;
      if (ack) fp <= fp + 16'd1;
      if (ack && state == FETCH_HI) inst[15:8] <= mem_rdata;
      if (ack && state == FETCH_LO) begin
        inst[7:0] <= mem_rdata;
        if (!word_needs_data) data <= '0;
      end
      if (ack && state == FETCH_DATA) data <= mem_rdata;
      // Branch target is relative to the issued instruction, wrapping mod 2^16.
      if (accept && branch_take) fp <= pc + branch_offset;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; expected bus addresses and
// issued instructions are queued by the stimulus and checked by monitors.
module tb_fetch_unit;
  typedef struct packed {
    logic [15:0] inst;
    logic [7:0]  data;
    logic [15:0] pc;
  } iss_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0, rst2_n = 1'b0;
  logic ack_en = 1'b0, ack_force = 1'b0, ack2_en = 1'b1;
  logic exec_ready = 1'b1, branch_take = 1'b0;
  logic [15:0] branch_offset = 16'h0000;
  logic [7:0] mem [0:65535];
  logic mem_req, mem_ack, en, fault;
  logic [15:0] mem_addr, inst, pc;
  logic [7:0] mem_rdata, data;
  logic mem_req2, mem_ack2, en2, fault2;
  logic [15:0] mem_addr2, inst2, pc2;
  logic [7:0] mem_rdata2, data2;
  iss_t exp_iss[$], exp_iss2[$];
  logic [15:0] exp_addr[$], exp_addr2[$];
  int checks = 0, errors = 0, n_iss = 0, n_iss2 = 0;
  always #5 clk = ~clk;
  assign mem_ack = (mem_req & ack_en) | ack_force;
  assign mem_rdata = mem[mem_addr];
  assign mem_ack2 = mem_req2 & ack2_en;
  assign mem_rdata2 = mem[mem_addr2];
  fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .en(en), .inst(inst), .data(data),
    .exec_ready(exec_ready), .branch_take(branch_take), .branch_offset(branch_offset),
    .pc(pc), .fault(fault));
  fetch_unit #(.RESET_PC(16'hFFFF), .TIMEOUT_CYCLES(16)) dut2 (
    .clk(clk), .rst_n(rst2_n), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_ack2), .mem_rdata(mem_rdata2), .en(en2), .inst(inst2), .data(data2),
    .exec_ready(1'b1), .branch_take(1'b0), .branch_offset(16'h0000),
    .pc(pc2), .fault(fault2));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      if (exp_addr.size() == 0) chk("addr_unexpected", {48'd0, mem_addr}, 64'hDEAD);
      else chk("addr", {48'd0, mem_addr}, {48'd0, exp_addr.pop_front()});
    end
    if (en && exec_ready) begin
      n_iss++;
      if (exp_iss.size() == 0) chk("issue_unexpected", {24'd0, inst, data, pc}, 64'hDEAD);
      else chk("issue", {24'd0, inst, data, pc}, {24'd0, exp_iss.pop_front()});
    end
  end
  always @(negedge clk) begin
    if (mem_req2 && mem_ack2) begin
      if (exp_addr2.size() == 0) chk("addr2_unexpected", {48'd0, mem_addr2}, 64'hDEAD);
      else chk("addr2", {48'd0, mem_addr2}, {48'd0, exp_addr2.pop_front()});
    end
    if (en2) begin
      n_iss2++;
      if (exp_iss2.size() == 0) chk("issue2_unexpected", {24'd0, inst2, data2, pc2}, 64'hDEAD);
      else chk("issue2", {24'd0, inst2, data2, pc2}, {24'd0, exp_iss2.pop_front()});
    end
  end
  task automatic wait_iss(input bit second, input int target);
    for (int i = 0; i < 60 && (second ? n_iss2 : n_iss) < target; i++) begin
      @(posedge clk);
      #2;
    end
    chk(second ? "issue2_timeout" : "issue_timeout", 64'((second ? n_iss2 : n_iss) >= target), 64'd1);
  endtask
  task automatic check_reset_outputs();
    chk("rst_en", {63'd0, en}, 64'd0);
    chk("rst_req", {63'd0, mem_req}, 64'd0);
    chk("rst_addr", {48'd0, mem_addr}, 64'd0);
    chk("rst_pc", {48'd0, pc}, 64'd0);
    chk("rst_inst", {48'd0, inst}, 64'd0);
    chk("rst_data", {56'd0, data}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
  endtask
  task automatic reset1();
    rst_n = 1'b0;
    ack_en = 1'b0;
    ack_force = 1'b0;
    exec_ready = 1'b1;
    branch_take = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs();
    rst_n = 1'b1;
  endtask
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    // plain word, no data byte
    mem[0] = 8'h00; mem[1] = 8'h05;
    reset1();
    exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0001);
    exp_iss.push_back('{16'h0005, 8'h00, 16'h0000});
    ack_en = 1'b1;
    wait_iss(0, 1);
    ack_en = 1'b0;
    chk("t1_next_req", {63'd0, mem_req}, 64'd1);
    chk("t1_next_addr", {48'd0, mem_addr}, 64'h0002);
    // one-arg word with data-sourced operand
    mem[0] = 8'h82; mem[1] = 8'h34; mem[2] = 8'h7A;
    reset1();
    exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0001); exp_addr.push_back(16'h0002);
    exp_iss.push_back('{16'h8234, 8'h7A, 16'h0000});
    ack_en = 1'b1;
    wait_iss(0, 2);
    ack_en = 1'b0;
    chk("t2_next_addr", {48'd0, mem_addr}, 64'h0003);
    // stalled issue, stray acks while idle, then a backward branch
    mem[0] = 8'hC0; mem[1] = 8'h10; mem[2] = 8'hEE;
    reset1();
    exec_ready = 1'b0;
    exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0001);
    ack_en = 1'b1;
    for (int i = 0; i < 20 && !en; i++) begin
      @(posedge clk);
      #2;
    end
    ack_en = 1'b0;
    ack_force = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_hold", {23'd0, en, inst, data, pc}, {23'd0, 1'b1, 16'hC010, 8'h00, 16'h0000});
      @(posedge clk);
      #2;
    end
    ack_force = 1'b0;
    exec_ready = 1'b1;
    branch_take = 1'b1;
    branch_offset = 16'hFFFC;
    exp_iss.push_back('{16'hC010, 8'h00, 16'h0000});
    wait_iss(0, 3);
    branch_take = 1'b0;
    chk("t3_branch_addr", {48'd0, mem_addr}, 64'hFFFC);
    chk("t3_en_drop", {63'd0, en}, 64'd0);
    // reset vector at the top of memory, word straddles the wrap
    mem[16'hFFFF] = 8'h88; mem[0] = 8'h01;
    #1;
    chk("t4_rst_addr", {48'd0, mem_addr2}, 64'hFFFF);
    chk("t4_rst_pc", {48'd0, pc2}, 64'hFFFF);
    chk("t4_rst_req", {63'd0, mem_req2}, 64'd0);
    exp_addr2.push_back(16'hFFFF); exp_addr2.push_back(16'h0000);
    exp_iss2.push_back('{16'h8801, 8'h00, 16'hFFFF});
    @(posedge clk);
    #2;
    rst2_n = 1'b1;
    wait_iss(1, 1);
    ack2_en = 1'b0;
    chk("t4_next_addr", {48'd0, mem_addr2}, 64'h0001);
    // reset while FETCH_LO is stalled, then a stray ack during reset
    mem[0] = 8'h12; mem[1] = 8'h34;
    reset1();
    exp_addr.push_back(16'h0000);
    ack_en = 1'b1;
    @(posedge clk);
    #2;
    ack_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("t5_stall_addr", {47'd0, mem_req, mem_addr}, {47'd0, 1'b1, 16'h0001});
    chk("t5_stall_hi", {48'd0, inst}, 64'h1200);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    check_reset_outputs();
    ack_force = 1'b1;
    @(posedge clk);
    #2;
    ack_force = 1'b0;
    chk("t5_stray_inst", {48'd0, inst}, 64'd0);
    chk("t5_stray_addr", {48'd0, mem_addr}, 64'd0);
    rst_n = 1'b1;
    exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0001);
    exp_iss.push_back('{16'h1234, 8'h00, 16'h0000});
    ack_en = 1'b1;
    wait_iss(0, 4);
    ack_en = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    reset1();
    chk("to_req_start", {63'd0, mem_req}, 64'd1);
    repeat (15) begin
      @(posedge clk);
      #2;
      chk("to_no_fault_yet", {62'd0, fault, mem_req}, 64'd1);
    end
    @(posedge clk);
    #2;
    chk("to_fault", {61'd0, fault, mem_req, en}, 64'b100);
    repeat (5) @(posedge clk);
    #2;
    chk("to_parked", {61'd0, fault, mem_req, en}, 64'b100);
`endif
    chk("addr_queue_empty", 64'(exp_addr.size() + exp_addr2.size()), 64'd0);
    chk("issue_queue_empty", 64'(exp_iss.size() + exp_iss2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Producer side of the instruction decoder's `inst`/`data`/`en` inputs.
- Fetches instruction bytes from an 8-bit memory bus, high byte first, into a 16-bit word.
- For one-arg instructions with a data-sourced operand, fetches one extra data byte.
- Presents the instruction to the decoder/execute stage with a hold-until-accepted handshake, then owns the PC, including sequential advance and taken branches.

Parameters:
- RESET_PC, 16'h0000, byte address of the first fetch after reset.
- TIMEOUT_CYCLES, 16, cycles without mem_ack before fault (only with FETCH_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- mem_req  output  1  byte read request.
- mem_addr  output  16  byte address; stable while mem_req && !mem_ack.
- mem_ack  input  1  mem_rdata valid this cycle; completes the transfer.
- mem_rdata  input  8  read byte.
- en  output  1  inst/data valid for decoder.
- inst  output  16  assembled instruction word.
- data  output  8  fetched data byte; 0 when none fetched.
- exec_ready  input  1  execute stage accepts the issued instruction this cycle.
- branch_take  input  1  sampled only when en && exec_ready.
- branch_offset  input  16  signed byte offset, sampled with branch_take.
- pc  output  16  address of the currently issued instruction's high byte.
- fault  output  1  bus timeout flag (FETCH_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=FETCH_HI, fetch pointer fp=RESET_PC, pc=RESET_PC.
  - inst=0, data=0, en=0, mem_req=0, mem_addr=RESET_PC, fault=0.
  - Reset mid-transfer abandons the transfer; a late mem_ack is ignored.
- States: FETCH_HI, FETCH_LO, FETCH_DATA, ISSUE.
- FETCH_HI:
  - Drive mem_req=1, mem_addr=fp; latch pc<=fp.
  - On mem_ack: inst[15:8]<=mem_rdata, fp<=fp+1, go to FETCH_LO.
- FETCH_LO:
  - Drive mem_req=1, mem_addr=fp.
  - On mem_ack: inst[7:0]<=mem_rdata, fp<=fp+1.
  - Next state is FETCH_DATA if needs_data, else ISSUE with data<=0.
- needs_data is true when inst[15:14]==2'b10 and inst[10:9]==2'b01 (source field 010 or 011). It is evaluated on the completed word.
- FETCH_DATA:
  - Drive mem_req=1, mem_addr=fp.
  - On mem_ack: data<=mem_rdata, fp<=fp+1, go to ISSUE.
- ISSUE:
  - en=1, mem_req=0; inst, data and pc are held stable until exec_ready.
  - exec_ready && !branch_take: next state FETCH_HI at the current fp.
  - exec_ready && branch_take: fp<=pc+branch_offset (mod 2^16), next state FETCH_HI.
  - en deasserts the cycle after acceptance.
- mem_req may stay high across back-to-back transfers. mem_addr updates the cycle after each ack.
- Minimum latency: instruction with no data byte and zero-wait ack → en 2 cycles after entering FETCH_HI. With a data byte → 3 cycles.
- Address wrap: fp 16'hFFFF+1 = 16'h0000. Instructions may straddle the wrap.
- mem_ack while mem_req=0 is ignored.
- branch_take is ignored outside acceptance.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs while mem_req && !mem_ack and clears on ack.
  - Reaching TIMEOUT_CYCLES sets fault=1, drops mem_req, and parks in a FAULT state.
  - FAULT is left only by reset. en stays 0 while in FAULT.
- Undefined: no counter or FAULT state; fault tied 0; waits indefinitely for mem_ack.

Decomposition:
- Shared package cpu_pkg:
  - opcode class masks (16'hC000 one-arg class, 16'hF800 opcode).
  - source field encodings (IMM_LO=3'b000, IMM_HI=3'b001, DATA_LO=3'b010, DATA_HI=3'b011, RAM=3'b100).
  - fetch state enum.
  - function needs_data(inst), so the fetch unit and decoder agree.
- No sub-module; optional timeout counter stays inline under the macro.

Test Plan:
- Bytes 00 05 at RESET_PC=0, ack every cycle, exec_ready=1 → en with inst=16'h0005, data=8'h00, pc=0; next fetch addr=2.
- Bytes 82 34 7A → 3 reads (addrs 0,1,2), en with inst=16'h8234, data=8'h7A; next fetch addr=3.
- Bytes C0 10, exec_ready held 0 for 4 cycles then 1 with branch_take=1, branch_offset=16'hFFFC → inst stable 5 cycles; next mem_addr=16'hFFFC.
- RESET_PC=16'hFFFF, bytes 88 01 → addrs FFFF then 0000; inst=16'h8801, pc=16'hFFFF.
- Assert rst_n=0 during FETCH_LO with mem_ack stalled → all outputs reset values next cycle; later stray mem_ack has no effect.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_ack never → fault=1 after 16 cycles of mem_req, mem_req=0, en stays 0 until reset.
